// File: rtl/game_pkg.sv
// Shared types, default constants and BCD helpers for the game-flow sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int DEF_TIK_PER_SEC    = 20;
  localparam int DEF_ROUND_SEC      = 60;
  localparam int DEF_SHOT_LIMIT     = 30;
  localparam int DEF_HIT_WIN        = 10;
  localparam int DEF_DEBOUNCE_TIKS  = 2;
  localparam int DEF_OVER_HOLD_TIKS = 40;

  // Elaboration-time conversion of a 0..99 parameter to {tens,units}.
  function automatic logic [7:0] bin2bcd8(input int value);
    return {4'((value / 10) % 10), 4'(value % 10)};
  endfunction

  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] value);
    if (value == 8'h99)
      return value;
    if (value[3:0] == 4'd9)
      return {value[7:4] + 4'd1, 4'd0};
    return {value[7:4], value[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec_floor(input logic [7:0] value);
    if (value == 8'h00)
      return value;
    if (value[3:0] == 4'd0)
      return {value[7:4] - 4'd1, 4'd9};
    return {value[7:4], value[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Tik-qualified key sampler: a press is accepted after DEBOUNCE_TIKS consecutive
// low samples and reported as a single strobe on the accepting tik.
module key_debounce #(
  parameter int DEBOUNCE_TIKS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tik,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_TIKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TIKS);

  // Saturates at CNT_MAX, which doubles as the debounced "pressed" level.
  logic [CNT_W-1:0] low_cnt;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      low_cnt <= '0;
    end else if (tik) begin
      if (key_n)
        low_cnt <= '0;
      else if (low_cnt != CNT_MAX)
        low_cnt <= low_cnt + CNT_W'(1);
    end
  end

  assign press = tik && !key_n && (low_cnt == CNT_MAX - CNT_W'(1));

endmodule

// File: rtl/game_flow_ctrl.sv
// Title/play/game-over sequencer: fire-key debounce, bullet grants and the BCD
// shot, hit and countdown counters shown on screen.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int TIK_PER_SEC    = DEF_TIK_PER_SEC,
  parameter int ROUND_SEC      = DEF_ROUND_SEC,
  parameter int SHOT_LIMIT     = DEF_SHOT_LIMIT,
  parameter int HIT_WIN        = DEF_HIT_WIN,
  parameter int DEBOUNCE_TIKS  = DEF_DEBOUNCE_TIKS,
  parameter int OVER_HOLD_TIKS = DEF_OVER_HOLD_TIKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tik,
  input  logic       key_fire,
  input  logic       bullet_busy,
  input  logic       hit,
  output logic [1:0] state,
  output logic       scene_en,
  output logic       fire_grant,
  output logic [7:0] shot_bcd,
  output logic [7:0] hit_bcd,
  output logic [7:0] time_bcd,
  output logic       win
);

  localparam logic [7:0] ROUND_BCD = bin2bcd8(ROUND_SEC);
  localparam logic [7:0] SHOT_BCD  = bin2bcd8(SHOT_LIMIT);
  localparam logic [7:0] WIN_BCD   = bin2bcd8(HIT_WIN);
  localparam int SEC_W  = $clog2(TIK_PER_SEC + 1);
  localparam int HOLD_W = $clog2(OVER_HOLD_TIKS + 2);
  localparam logic [SEC_W-1:0]  SEC_LAST = SEC_W'(TIK_PER_SEC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD_TIKS);

  state_t            state_q, state_d;
  logic [7:0]        shot_q, shot_d, hit_q, hit_d, time_q, time_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              win_q, win_d, grant_q, grant_d;
  logic              press;

  key_debounce #(.DEBOUNCE_TIKS(DEBOUNCE_TIKS)) u_fire_debounce (
    .clk   (clk),
    .rst   (rst),
    .tik   (tik),
    .key_n (key_fire),
    .press (press)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shot_q  <= 8'h00;
      hit_q   <= 8'h00;
      time_q  <= ROUND_BCD;
      sec_q   <= '0;
      hold_q  <= '0;
      win_q   <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shot_q  <= shot_d;
      hit_q   <= hit_d;
      time_q  <= time_d;
      sec_q   <= sec_d;
      hold_q  <= hold_d;
      win_q   <= win_d;
      grant_q <= grant_d;
    end
  end

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    shot_d  = shot_q;
    hit_d   = hit_q;
    time_d  = time_q;
    sec_d   = sec_q;
    hold_d  = hold_q;
    win_d   = win_q;
    grant_d = 1'b0;
    if (tik) begin
      case (state_q)
        ST_IDLE: begin
          if (press) begin
            state_d = ST_PLAY;
            shot_d  = 8'h00;
            hit_d   = 8'h00;
            time_d  = ROUND_BCD;
            sec_d   = '0;
            win_d   = 1'b0;
          end
        end
        ST_PLAY: begin
          grant_d = press && !bullet_busy && (shot_q < SHOT_BCD);
          if (grant_d)
            shot_d = bcd_inc_sat(shot_q);
          if (hit)
            hit_d = bcd_inc_sat(hit_q);
          if (sec_q == SEC_LAST) begin
            sec_d  = '0;
            time_d = bcd_dec_floor(time_q);
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
          hold_d = '0;
          // Out-of-shots uses the pre-tik count so the final bullet gets to fly.
          if (hit_d >= WIN_BCD) begin
            state_d = ST_OVER;
            win_d   = 1'b1;
          end else if ((time_d == 8'h00) ||
                       ((shot_q == SHOT_BCD) && !bullet_busy && !hit)) begin
            state_d = ST_OVER;
            win_d   = 1'b0;
          end
        end
        ST_OVER: begin
          if (hold_q != HOLD_MAX)
            hold_d = hold_q + HOLD_W'(1);
          else if (press)
            state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    state      = state_q;
    scene_en   = (state_q == ST_PLAY);
    fire_grant = grant_q;
    shot_bcd   = shot_q;
    hit_bcd    = hit_q;
    time_bcd   = time_q;
    win        = win_q;
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: three parameterisations share one stimulus stream and
// are compared every cycle against an integer-count model of the game rules.
module tb_game_flow_ctrl;

  localparam int TPS   = 20;
  localparam int ROUND = 60;
  localparam int DBT   = 2;
  localparam int HOLD  = 40;
  localparam int S_IDLE = 0, S_PLAY = 1, S_OVER = 2;

  logic clk = 1'b0;
  logic rst, tik, key_fire, bullet_busy, hit;
  logic [1:0] st [3];
  logic       se [3];
  logic       fg [3];
  logic [7:0] sh [3];
  logic [7:0] hi [3];
  logic [7:0] ti [3];
  logic       w  [3];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: plain counts, converted to BCD only for comparison.
  int m_low;
  int m_st [3];
  int m_shots [3];
  int m_hits [3];
  int m_secs [3];
  int m_div [3];
  int m_hold [3];
  bit m_win [3];
  bit m_grant [3];

  always #5 clk = ~clk;

  game_flow_ctrl #(.HIT_WIN(99)) dut0 (
    .clk(clk), .rst(rst), .tik(tik), .key_fire(key_fire), .bullet_busy(bullet_busy),
    .hit(hit), .state(st[0]), .scene_en(se[0]), .fire_grant(fg[0]), .shot_bcd(sh[0]),
    .hit_bcd(hi[0]), .time_bcd(ti[0]), .win(w[0]));

  game_flow_ctrl dut1 (
    .clk(clk), .rst(rst), .tik(tik), .key_fire(key_fire), .bullet_busy(bullet_busy),
    .hit(hit), .state(st[1]), .scene_en(se[1]), .fire_grant(fg[1]), .shot_bcd(sh[1]),
    .hit_bcd(hi[1]), .time_bcd(ti[1]), .win(w[1]));

  game_flow_ctrl #(.SHOT_LIMIT(3)) dut2 (
    .clk(clk), .rst(rst), .tik(tik), .key_fire(key_fire), .bullet_busy(bullet_busy),
    .hit(hit), .state(st[2]), .scene_en(se[2]), .fire_grant(fg[2]), .shot_bcd(sh[2]),
    .hit_bcd(hi[2]), .time_bcd(ti[2]), .win(w[2]));

  function automatic int hwin(input int i);
    return (i == 0) ? 99 : 10;
  endfunction

  function automatic int slim(input int i);
    return (i == 2) ? 3 : 30;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [28:0] obs(input int i);
    return {st[i], se[i], fg[i], sh[i], hi[i], ti[i], w[i]};
  endfunction

  function automatic logic [28:0] expv(input int i);
    return {2'(m_st[i]), (m_st[i] == S_PLAY), m_grant[i], bcd(m_shots[i]),
            bcd(m_hits[i]), bcd(m_secs[i]), m_win[i]};
  endfunction

  // Advance the rules model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    bit press;
    int shots_before;
    press = 1'b0;
    if (!rst) begin
      m_low = 0;
      for (int i = 0; i < 3; i++) begin
        m_st[i] = S_IDLE; m_shots[i] = 0; m_hits[i] = 0; m_secs[i] = ROUND;
        m_div[i] = 0; m_hold[i] = 0; m_win[i] = 1'b0; m_grant[i] = 1'b0;
      end
    end else begin
      if (tik) begin
        if (key_fire) m_low = 0;
        else if (m_low < DBT) begin
          m_low++;
          press = (m_low == DBT);
        end
      end
      for (int i = 0; i < 3; i++) begin
        shots_before = m_shots[i];
        m_grant[i] = 1'b0;
        if (tik) begin
          if (m_st[i] == S_IDLE) begin
            if (press) begin
              m_st[i] = S_PLAY; m_shots[i] = 0; m_hits[i] = 0; m_secs[i] = ROUND;
              m_div[i] = 0; m_win[i] = 1'b0;
            end
          end else if (m_st[i] == S_PLAY) begin
            if (press && !bullet_busy && m_shots[i] < slim(i)) begin
              m_shots[i]++;
              m_grant[i] = 1'b1;
            end
            if (hit && m_hits[i] < 99) m_hits[i]++;
            m_div[i]++;
            if (m_div[i] == TPS) begin
              m_div[i] = 0;
              if (m_secs[i] > 0) m_secs[i]--;
            end
            if (m_hits[i] >= hwin(i)) begin
              m_st[i] = S_OVER; m_win[i] = 1'b1; m_hold[i] = 0;
            end else if (m_secs[i] == 0 ||
                         (shots_before == slim(i) && !bullet_busy && !hit)) begin
              m_st[i] = S_OVER; m_win[i] = 1'b0; m_hold[i] = 0;
            end
          end else begin
            if (m_hold[i] < HOLD) m_hold[i]++;
            else if (press) m_st[i] = S_IDLE;
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit tk);
    tik = tk;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round();
    rst = 1'b0; key_fire = 1'b1; bullet_busy = 1'b0; hit = 1'b0;
    cyc(1'b0);
    rst = 1'b1; key_fire = 1'b0;
    cyc(1'b1);
    cyc(1'b1);
    key_fire = 1'b1;
    cyc(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; key_fire = 1'b0; bullet_busy = 1'b1; hit = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs(i) !== expv(i))
          $display("FAIL reset_model inst%0d c%0d got %h exp %h", i, c, obs(i), expv(i));
        else n_pass++;
      end
    end
    n_checks++;
    if ({st[1], se[1], fg[1], sh[1], hi[1], ti[1], w[1]} !== {2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h60, 1'b0})
      $display("FAIL reset_values got %h exp %h", obs(1), {2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h60, 1'b0});
    else n_pass++;
  endtask

  task automatic test_start();
    rst = 1'b1; bullet_busy = 1'b0; hit = 1'b0;
    for (int c = 0; c < 30; c++) begin
      key_fire = (c < 2) ? 1'b0 : 1'b1;
      hit = (c == 10 || c == 11);
      if (c == 29) rst = 1'b0;
      cyc(1'b1);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs(i) !== expv(i))
          $display("FAIL start_model inst%0d c%0d got %h exp %h", i, c, obs(i), expv(i));
        else n_pass++;
      end
      if (c == 0) begin
        n_checks++;
        if (st[1] !== 2'd0) $display("FAIL start_one_low state got %0d exp 0", st[1]);
        else n_pass++;
      end
      if (c == 1) begin
        n_checks++;
        if ({st[1], se[1], fg[1], ti[1]} !== {2'd1, 1'b1, 1'b0, 8'h60})
          $display("FAIL start_play got %h exp %h", {st[1], se[1], fg[1], ti[1]}, {2'd1, 1'b1, 1'b0, 8'h60});
        else n_pass++;
      end
    end
    n_checks++;
    if ({st[1], se[1], sh[1], hi[1], ti[1]} !== {2'd0, 1'b0, 8'h00, 8'h00, 8'h60})
      $display("FAIL midplay_reset got %h exp %h", {st[1], se[1], sh[1], hi[1], ti[1]}, {2'd0, 1'b0, 8'h00, 8'h00, 8'h60});
    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_fire();
    int grants;
    grants = 0;
    start_round();
    for (int c = 0; c < 77; c++) begin
      if (c < 18)      begin key_fire = !((c % 6) == 2 || (c % 6) == 3); bullet_busy = 1'b0; end
      else if (c < 68) begin key_fire = 1'b0; bullet_busy = 1'b0; end
      else if (c < 71) begin key_fire = 1'b1; bullet_busy = 1'b0; end
      else if (c < 73) begin key_fire = 1'b0; bullet_busy = 1'b1; end
      else             begin key_fire = 1'b1; bullet_busy = 1'b0; end
      cyc(1'b1);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs(i) !== expv(i))
          $display("FAIL fire_model inst%0d c%0d got %h exp %h", i, c, obs(i), expv(i));
        else n_pass++;
      end
      if (fg[1] === 1'b1) grants++;
      if (c == 17) begin
        n_checks++;
        if ({grants, sh[1]} !== {32'd3, 8'h03})
          $display("FAIL fire_three grants %0d shot %h exp 3 03", grants, sh[1]);
        else n_pass++;
      end
    end
    n_checks++;
    if ({grants, sh[1]} !== {32'd4, 8'h04})
      $display("FAIL fire_hold_busy grants %0d shot %h exp 4 04", grants, sh[1]);
    else n_pass++;
  endtask

  task automatic test_hits();
    start_round();
    for (int c = 0; c < 36; c++) begin
      hit = (c < 33) && (c % 3 == 0);
      cyc(1'b1);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs(i) !== expv(i))
          $display("FAIL hits_model inst%0d c%0d got %h exp %h", i, c, obs(i), expv(i));
        else n_pass++;
      end
      if (c == 24 || c == 27 || c == 30) begin
        n_checks++;
        if (hi[0] !== ((c == 24) ? 8'h09 : (c == 27) ? 8'h10 : 8'h11))
          $display("FAIL hits_bcd_carry c%0d got %h", c, hi[0]);
        else n_pass++;
      end
      if (c == 27) begin
        n_checks++;
        if ({st[1], w[1], hi[1]} !== {2'd2, 1'b1, 8'h10})
          $display("FAIL hits_win got %h exp %h", {st[1], w[1], hi[1]}, {2'd2, 1'b1, 8'h10});
        else n_pass++;
      end
    end
    hit = 1'b0;
  endtask

  task automatic test_timeout();
    start_round();
    for (int c = 0; c < 1202; c++) begin
      cyc(1'b1);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs(i) !== expv(i))
          $display("FAIL timeout_model inst%0d c%0d got %h exp %h", i, c, obs(i), expv(i));
        else n_pass++;
      end
      if (c == 19 || c == 999 || c == 1019) begin
        n_checks++;
        if (ti[0] !== ((c == 19) ? 8'h59 : (c == 999) ? 8'h10 : 8'h09))
          $display("FAIL timeout_step c%0d got %h", c, ti[0]);
        else n_pass++;
      end
      if (c == 1198) begin
        n_checks++;
        if ({st[0], ti[0]} !== {2'd1, 8'h01})
          $display("FAIL timeout_last_sec got %h exp %h", {st[0], ti[0]}, {2'd1, 8'h01});
        else n_pass++;
      end
      if (c == 1199) begin
        n_checks++;
        if ({st[0], w[0], ti[0]} !== {2'd2, 1'b0, 8'h00})
          $display("FAIL timeout_over got %h exp %h", {st[0], w[0], ti[0]}, {2'd2, 1'b0, 8'h00});
        else n_pass++;
      end
    end
  endtask

  task automatic test_win_vs_timeout();
    start_round();
    for (int c = 0; c < 1201; c++) begin
      hit = (c < 9) || (c == 1199);
      cyc(1'b1);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs(i) !== expv(i))
          $display("FAIL winto_model inst%0d c%0d got %h exp %h", i, c, obs(i), expv(i));
        else n_pass++;
      end
      if (c == 1199) begin
        n_checks++;
        if ({st[1], w[1], hi[1], ti[1], st[0], w[0]} !== {2'd2, 1'b1, 8'h10, 8'h00, 2'd2, 1'b0})
          $display("FAIL win_beats_timeout got %h", {st[1], w[1], hi[1], ti[1], st[0], w[0]});
        else n_pass++;
      end
    end
    hit = 1'b0;
  endtask

  task automatic test_shot_limit();
    start_round();
    for (int c = 0; c < 75; c++) begin
      if (c < 24) begin
        key_fire    = !((c % 8) == 2 || (c % 8) == 3);
        bullet_busy = ((c % 8) >= 4 && (c % 8) <= 6);
      end else begin
        key_fire    = !(c == 30 || c == 31 || c == 70 || c == 71);
        bullet_busy = 1'b0;
      end
      cyc(1'b1);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs(i) !== expv(i))
          $display("FAIL limit_model inst%0d c%0d got %h exp %h", i, c, obs(i), expv(i));
        else n_pass++;
      end
      if (c == 22 || c == 32) begin
        n_checks++;
        if (st[2] !== ((c == 22) ? 2'd1 : 2'd2))
          $display("FAIL limit_state c%0d got %0d", c, st[2]);
        else n_pass++;
      end
      if (c == 23) begin
        n_checks++;
        if ({st[2], w[2], sh[2]} !== {2'd2, 1'b0, 8'h03})
          $display("FAIL limit_over got %h exp %h", {st[2], w[2], sh[2]}, {2'd2, 1'b0, 8'h03});
        else n_pass++;
      end
      if (c == 71) begin
        n_checks++;
        if ({st[2], se[2], sh[2]} !== {2'd0, 1'b0, 8'h03})
          $display("FAIL limit_to_idle got %h exp %h", {st[2], se[2], sh[2]}, {2'd0, 1'b0, 8'h03});
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    rst = 1'b0; key_fire = 1'b1; bullet_busy = 1'b0; hit = 1'b0;
    cyc(1'b0);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 7) == 0) key_fire = ~key_fire;
      if ($urandom_range(0, 5) == 0) bullet_busy = ~bullet_busy;
      hit = ($urandom_range(0, 9) == 0);
      cyc($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs(i) !== expv(i))
          $display("FAIL random_model inst%0d c%0d got %h exp %h", i, c, obs(i), expv(i));
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b0; tik = 1'b0; key_fire = 1'b1; bullet_busy = 1'b0; hit = 1'b0;
    #1;
    test_reset();
    test_start();
    test_fire();
    test_hits();
    test_timeout();
    test_win_vs_timeout();
    test_shot_limit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
